// File: rtl/g2_chain_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : g2_chain_search_ctrl
// Purpose  : Sequencer for one G2 hash-chain table. Accepts search requests,
//            walks the linked entries (one index per hop, 2 cycles per hop),
//            accumulates match/ruleID and returns one response per request.
//            Also arbitrates single-entry table writes from the update engine
//            against searches so the table has exactly one owner.
// Option   : G2_FIRST_MATCH_EN - when defined, the walk stops at the first
//            matching entry; otherwise the whole chain is walked and the
//            numerically smallest matching ruleID is returned.
// Ports    : clk, rst_n (async, active low)
//            req_*  : search request (valid/ready, tuple, chain head index)
//            rsp_*  : search response (valid/ready, match, ruleID, hops,
//                     overflow)
//            upd_*  : table write request (valid/ready, index, data)
//            tbl_*  : registered drive to the table / registered results
//                     returned by it (1-cycle read latency)
// Revision : 1.0 - initial release
// ============================================================================
module g2_chain_search_ctrl #(
  parameter int                       INDEX_BIT_LEN    = 11,
  parameter int                       PACKET_BIT_LEN   = 104,
  parameter int                       ENTRY_DATA_WIDTH = 171,
  parameter logic [INDEX_BIT_LEN-1:0] NULL_INDEX       = 11'h7FF,
  parameter int                       MAX_HOPS         = 19,
  parameter int                       HOP_W            = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [PACKET_BIT_LEN-1:0]   req_tuple,
  input  logic [INDEX_BIT_LEN-1:0]    req_start_index,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_match,
  output logic [INDEX_BIT_LEN-1:0]    rsp_ruleID,
  output logic [HOP_W-1:0]            rsp_hops,
  output logic                        rsp_overflow,
  input  logic                        upd_valid,
  output logic                        upd_ready,
  input  logic [INDEX_BIT_LEN-1:0]    upd_index,
  input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,
  output logic [INDEX_BIT_LEN-1:0]    tbl_search_index,
  output logic [PACKET_BIT_LEN-1:0]   tbl_tupleData,
  output logic                        tbl_we,
  output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
  input  logic                        tbl_match,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
  input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t                     state;
  state_t                     state_nxt;

  // Arbitration pointer: 1 when the most recent grant went to a search.
  logic                       last_req;
  logic [HOP_W-1:0]           hops;
  logic                       acc_match;
  logic [INDEX_BIT_LEN-1:0]   acc_rule;

  logic                       upd_grant;
  logic                       req_grant;
  logic                       start_null;
  logic [HOP_W-1:0]           hops_inc;
  logic                       take_hit;
  logic                       match_nxt;
  logic [INDEX_BIT_LEN-1:0]   rule_nxt;
  logic                       at_null;
  logic                       at_limit;
  logic                       stop_first;
  logic                       walk_done;
  logic                       overflow_nxt;

  // Update wins when alone or when the previous grant was a search, so the
  // two sources alternate under sustained contention.
  always_comb begin
    upd_grant = upd_valid && (!req_valid || last_req);
    req_grant = req_valid && !upd_grant;
  end

  assign upd_ready  = (state == IDLE) && upd_grant;
  assign req_ready  = (state == IDLE) && req_grant;
  assign start_null = (req_start_index == NULL_INDEX);

  // Per-hop evaluation of the table result; only meaningful in WAIT.
  always_comb begin
    hops_inc  = hops + 1'b1;
    // Strict compare keeps the first-seen entry on equal ruleIDs.
    take_hit  = tbl_match && (!acc_match || (tbl_ruleID < acc_rule));
    match_nxt = acc_match || tbl_match;
    rule_nxt  = take_hit ? tbl_ruleID : acc_rule;
    at_null   = (tbl_next_index == NULL_INDEX);
    at_limit  = (hops_inc == HOP_W'(MAX_HOPS));
`ifdef G2_FIRST_MATCH_EN
    stop_first = tbl_match;
`else
    stop_first = 1'b0;
`endif
    walk_done    = stop_first || at_null || at_limit;
    // A chain that ends exactly on the last permitted hop is not an overflow.
    overflow_nxt = !stop_first && !at_null && at_limit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (upd_grant) begin
          state_nxt = WRITE;
        end else if (req_grant) begin
          state_nxt = start_null ? RESP : ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = walk_done ? RESP : ISSUE;
      RESP:    state_nxt = rsp_ready ? IDLE : RESP;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. tbl_search_index doubles as the current chain index: it is
  // loaded on entry to ISSUE so the table sees it for the whole ISSUE cycle
  // and returns the entry in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_req         <= 1'b1;
      hops             <= '0;
      acc_match        <= 1'b0;
      acc_rule         <= '0;
      rsp_valid        <= 1'b0;
      rsp_match        <= 1'b0;
      rsp_ruleID       <= '0;
      rsp_hops         <= '0;
      rsp_overflow     <= 1'b0;
      tbl_search_index <= '0;
      tbl_tupleData    <= '0;
      tbl_we           <= 1'b0;
      tbl_din          <= '0;
    end else begin
      tbl_we <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_grant) begin
            last_req         <= 1'b0;
            tbl_we           <= 1'b1;
            tbl_search_index <= upd_index;
            tbl_din          <= upd_data;
          end else if (req_grant) begin
            last_req         <= 1'b1;
            tbl_tupleData    <= req_tuple;
            tbl_search_index <= req_start_index;
            hops             <= '0;
            acc_match        <= 1'b0;
            acc_rule         <= '0;
            if (start_null) begin
              rsp_valid    <= 1'b1;
              rsp_match    <= 1'b0;
              rsp_ruleID   <= '0;
              rsp_hops     <= '0;
              rsp_overflow <= 1'b0;
            end
          end
        end
        WAIT: begin
          hops      <= hops_inc;
          acc_match <= match_nxt;
          acc_rule  <= rule_nxt;
          if (walk_done) begin
            rsp_valid    <= 1'b1;
            rsp_match    <= match_nxt;
            rsp_ruleID   <= rule_nxt;
            rsp_hops     <= hops_inc;
            rsp_overflow <= overflow_nxt;
          end else begin
            tbl_search_index <= tbl_next_index;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_g2_chain_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_g2_chain_search_ctrl
// Purpose  : Self-checking bench for g2_chain_search_ctrl. Contains a
//            behavioural table (registered read, written through tbl_we), a
//            shadow copy of the intended table contents, a chain-walk model
//            that derives the expected response and latency for every
//            accepted request, and directed scenarios with literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_g2_chain_search_ctrl;

  localparam int IW   = 11;
  localparam int PW   = 104;
  localparam int EW   = 171;
  localparam int MAXH = 19;
  localparam int HW   = 5;
  localparam logic [IW-1:0] NULLI = 11'h7FF;

  localparam logic [PW-1:0] T  = 104'h0123456789ABCDEF0011223344;
  localparam logic [PW-1:0] UT = 104'hFEDCBA98765432100011223344;
  localparam logic [PW-1:0] VT = 104'h00000000000000000000000055;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [PW-1:0] req_tuple;
  logic [IW-1:0] req_start_index;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_match;
  logic [IW-1:0] rsp_ruleID;
  logic [HW-1:0] rsp_hops;
  logic          rsp_overflow;
  logic          upd_valid;
  logic          upd_ready;
  logic [IW-1:0] upd_index;
  logic [EW-1:0] upd_data;
  logic [IW-1:0] tbl_search_index;
  logic [PW-1:0] tbl_tupleData;
  logic          tbl_we;
  logic [EW-1:0] tbl_din;
  logic          tbl_match;
  logic [IW-1:0] tbl_ruleID;
  logic [IW-1:0] tbl_next_index;

  g2_chain_search_ctrl #(
    .INDEX_BIT_LEN(IW), .PACKET_BIT_LEN(PW), .ENTRY_DATA_WIDTH(EW),
    .NULL_INDEX(NULLI), .MAX_HOPS(MAXH), .HOP_W(HW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tuple(req_tuple),
    .req_start_index(req_start_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_match(rsp_match),
    .rsp_ruleID(rsp_ruleID), .rsp_hops(rsp_hops), .rsp_overflow(rsp_overflow),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_data(upd_data),
    .tbl_search_index(tbl_search_index), .tbl_tupleData(tbl_tupleData),
    .tbl_we(tbl_we), .tbl_din(tbl_din),
    .tbl_match(tbl_match), .tbl_ruleID(tbl_ruleID),
    .tbl_next_index(tbl_next_index)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Entry layout used by this bench: {pad, valid, tuple, ruleID, next}.
  function automatic logic [EW-1:0] mk(input logic [PW-1:0] t, input logic [IW-1:0] rl,
                                       input logic [IW-1:0] nx);
    return {44'd0, 1'b1, t, rl, nx};
  endfunction

  // Behavioural table with registered read.
  bit          tm_v [2048];
  bit [PW-1:0] tm_t [2048];
  bit [IW-1:0] tm_r [2048];
  bit [IW-1:0] tm_n [2048];

  always @(posedge clk) begin
    if (tbl_we) begin
      tm_v[tbl_search_index] <= tbl_din[126];
      tm_t[tbl_search_index] <= tbl_din[125:22];
      tm_r[tbl_search_index] <= tbl_din[21:11];
      tm_n[tbl_search_index] <= tbl_din[10:0];
    end
    tbl_match      <= tm_v[tbl_search_index] && (tm_t[tbl_search_index] == tbl_tupleData);
    tbl_ruleID     <= tm_r[tbl_search_index];
    tbl_next_index <= tm_v[tbl_search_index] ? tm_n[tbl_search_index] : NULLI;
  end

  // Shadow of the table contents the bench intends to hold.
  bit          sh_v [2048];
  bit [PW-1:0] sh_t [2048];
  bit [IW-1:0] sh_r [2048];
  bit [IW-1:0] sh_n [2048];

  typedef struct {
    logic          m;
    logic [IW-1:0] rule;
    logic [HW-1:0] hops;
    logic          ov;
    int            due;
  } exp_t;

  // Expected search outcome from a straight walk of the shadow table.
  function automatic exp_t walk(input logic [PW-1:0] t, input logic [IW-1:0] s);
    exp_t          e;
    logic [IW-1:0] idx;
    int            h;
    bit            stopped;
    e.m = 1'b0; e.rule = '0; e.hops = '0; e.ov = 1'b0; e.due = 0;
    idx = s; h = 0; stopped = 1'b0;
    while (idx != NULLI && h < MAXH && !stopped) begin
      h++;
      if (sh_v[idx] && sh_t[idx] == t) begin
`ifdef G2_FIRST_MATCH_EN
        e.m = 1'b1; e.rule = sh_r[idx]; stopped = 1'b1;
`else
        if (!e.m || sh_r[idx] < e.rule) e.rule = sh_r[idx];
        e.m = 1'b1;
`endif
      end
      if (!stopped) idx = sh_v[idx] ? sh_n[idx] : NULLI;
    end
    e.hops = HW'(h);
    e.ov   = !stopped && (idx != NULLI);
    return e;
  endfunction

  exp_t          sb[$];
  int            glog[$];
  bit            we_exp     = 1'b0;
  logic [IW-1:0] we_idx;
  logic [EW-1:0] we_dat;
  bit            last_req_m = 1'b1;
  bit            front_seen = 1'b0;
  bit            late_rep   = 1'b0;
  bit            idle_m, eu, er;
  exp_t          cur_e;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: every cycle, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      we_exp = 1'b0; last_req_m = 1'b1; front_seen = 1'b0; late_rep = 1'b0;
    end else begin
      idle_m = (sb.size() == 0) && !we_exp;
      eu = idle_m && upd_valid && (!req_valid || last_req_m);
      er = idle_m && req_valid && !eu;
      if (upd_valid || req_valid) begin
        chk("upd_ready", upd_ready, eu);
        chk("req_ready", req_ready, er);
      end
      chk("tbl_we", tbl_we, we_exp);
      if (we_exp) begin
        chk("tbl_wr_index", tbl_search_index, we_idx);
        chk("tbl_din", tbl_din, we_dat);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_valid_unexpected", rsp_valid, 0);
        end else begin
          if (!front_seen) begin
            chk("rsp_latency", cyc, sb[0].due);
            front_seen = 1'b1;
          end
          chk("rsp_match", rsp_match, sb[0].m);
          chk("rsp_ruleID", rsp_ruleID, sb[0].rule);
          chk("rsp_hops", rsp_hops, sb[0].hops);
          chk("rsp_overflow", rsp_overflow, sb[0].ov);
          if (rsp_ready) begin
            void'(sb.pop_front());
            front_seen = 1'b0;
            late_rep   = 1'b0;
          end
        end
      end else if (sb.size() > 0 && !front_seen && !late_rep && cyc > sb[0].due) begin
        chk("rsp_late", cyc, sb[0].due);
        late_rep = 1'b1;
      end
      if (upd_valid && upd_ready) glog.push_back(1);
      if (req_valid && req_ready) glog.push_back(2);
      we_exp = 1'b0;
      if (eu) begin
        we_exp = 1'b1; we_idx = upd_index; we_dat = upd_data; last_req_m = 1'b0;
        sh_v[upd_index] = upd_data[126];
        sh_t[upd_index] = upd_data[125:22];
        sh_r[upd_index] = upd_data[21:11];
        sh_n[upd_index] = upd_data[10:0];
      end
      if (er) begin
        cur_e     = walk(req_tuple, req_start_index);
        cur_e.due = cyc + 2 * int'(cur_e.hops) + 1;
        sb.push_back(cur_e);
        last_req_m = 1'b1;
      end
    end
  end

  task automatic do_write(input logic [IW-1:0] idx, input logic [PW-1:0] t,
                          input logic [IW-1:0] rl, input logic [IW-1:0] nx);
    bit got;
    got = 1'b0;
    upd_valid = 1'b1; upd_index = idx; upd_data = mk(t, rl, nx);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (upd_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    if (!got) chk("upd_accept_timeout", 0, 1);
  endtask

  task automatic do_search(input logic [PW-1:0] t, input logic [IW-1:0] s, input int hold,
                           output logic m, output logic [IW-1:0] r, output logic [HW-1:0] h,
                           output logic ov, output int lat);
    bit got;
    int acc;
    m = 1'b0; r = '0; h = '0; ov = 1'b0; lat = -1; acc = 0;
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_tuple = t; req_start_index = s;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1'b1; acc = cyc; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!got) begin
      chk("req_accept_timeout", 0, 1);
      return;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1; lat = cyc - acc;
        m = rsp_match; r = rsp_ruleID; h = rsp_hops; ov = rsp_overflow;
      end
    end
    if (!got) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  logic          m1, ov1, m2, ov2;
  logic [IW-1:0] r1, r2;
  logic [HW-1:0] h1, h2;
  int            lat1, lat2;
  bit            got_acc;

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_match"}, rsp_match, 0);
    chk({tag, "_rsp_ruleID"}, rsp_ruleID, 0);
    chk({tag, "_rsp_hops"}, rsp_hops, 0);
    chk({tag, "_rsp_overflow"}, rsp_overflow, 0);
    chk({tag, "_tbl_we"}, tbl_we, 0);
    chk({tag, "_tbl_search_index"}, tbl_search_index, 0);
    chk({tag, "_tbl_tupleData"}, tbl_tupleData, 0);
    chk({tag, "_tbl_din"}, tbl_din, 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; upd_valid = 1'b0; rsp_ready = 1'b1;
    req_tuple = '0; req_start_index = '0; upd_index = '0; upd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-entry chain.
    do_write(11'd5, T, 11'd12, NULLI);
    do_search(T, 11'd5, 0, m1, r1, h1, ov1, lat1);
    chk("single_match", m1, 1); chk("single_rule", r1, 12);
    chk("single_hops", h1, 1); chk("single_ov", ov1, 0); chk("single_lat", lat1, 3);

    // Chain 2 -> 9 -> 4 with matches at 9 (30) and 4 (8).
    do_write(11'd2, UT, 11'd40, 11'd9);
    do_write(11'd9, T, 11'd30, 11'd4);
    do_write(11'd4, T, 11'd8, NULLI);
    do_search(T, 11'd2, 0, m1, r1, h1, ov1, lat1);
    chk("chain_match", m1, 1); chk("chain_ov", ov1, 0);
`ifdef G2_FIRST_MATCH_EN
    chk("chain_rule", r1, 30); chk("chain_hops", h1, 2); chk("chain_lat", lat1, 5);
`else
    chk("chain_rule", r1, 8); chk("chain_hops", h1, 3); chk("chain_lat", lat1, 7);
`endif

    // Null chain head.
    do_search(T, NULLI, 0, m1, r1, h1, ov1, lat1);
    chk("null_match", m1, 0); chk("null_rule", r1, 0);
    chk("null_hops", h1, 0); chk("null_ov", ov1, 0); chk("null_lat", lat1, 1);

    // Never-written index: one hop, no match.
    do_search(T, 11'd50, 0, m1, r1, h1, ov1, lat1);
    chk("empty_match", m1, 0); chk("empty_hops", h1, 1); chk("empty_ov", ov1, 0);

    // Self-loop on a non-matching entry hits the hop limit.
    do_write(11'd3, UT, 11'd25, 11'd3);
    do_search(T, 11'd3, 0, m1, r1, h1, ov1, lat1);
    chk("loop_match", m1, 0); chk("loop_rule", r1, 0);
    chk("loop_hops", h1, 19); chk("loop_ov", ov1, 1); chk("loop_lat", lat1, 39);

    // Response held for several cycles by back-pressure.
    do_search(T, 11'd2, 4, m1, r1, h1, ov1, lat1);
    chk("hold_match", m1, 1);

    // Contention: previous grant was a search, so the update goes first.
    glog.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) do_write(IW'(100 + i), VT, IW'(50 + i), NULLI);
      end
      begin
        for (int j = 0; j < 4; j++) do_search(T, 11'd5, 0, m2, r2, h2, ov2, lat2);
      end
    join
    chk("arb_grants", glog.size(), 8);
    for (int k = 0; k < glog.size() && k < 8; k++)
      chk($sformatf("arb_order_%0d", k), glog[k], (k % 2 == 0) ? 1 : 2);
    chk("arb_last_rule", r2, 12);

    // Reset during WAIT of a 3-hop walk with the response blocked.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_tuple = T; req_start_index = 11'd2;
    got_acc = 1'b0;
    for (int i = 0; i < 50 && !got_acc; i++) begin
      @(negedge clk);
      if (req_ready) got_acc = 1'b1;
    end
    chk("abort_accept", got_acc, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_rsp", rsp_valid, 0);
    rsp_ready = 1'b1;
    do_search(T, 11'd5, 0, m1, r1, h1, ov1, lat1);
    chk("post_match", m1, 1); chk("post_rule", r1, 12);
    chk("post_hops", h1, 1); chk("post_lat", lat1, 3);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/g2_chain_search_ctrl.md
Name: g2_chain_search_ctrl

Overview:
- Sequencer for one G2 hash-chain table.
- Accepts packet search requests, walks the linked entries by driving the table's search index and tuple, and follows the next index returned with each entry.
- Collects match and ruleID, then returns one response per request.
- Also arbitrates single-entry table writes from the update engine against searches, so the table has exactly one owner.

Parameters:
- INDEX_BIT_LEN, 11, width of table index and ruleID.
- PACKET_BIT_LEN, 104, width of the packet tuple.
- ENTRY_DATA_WIDTH, 171, width of one table entry.
- NULL_INDEX, 11'h7FF, next-index value that terminates a chain.
- MAX_HOPS, 19, maximum entries visited per search (loop guard).
- HOP_W, 5, width of the hop counter; must hold MAX_HOPS.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  search request valid.
- req_ready  out  1  search request accepted when high with req_valid.
- req_tuple  in  PACKET_BIT_LEN  packet header tuple.
- req_start_index  in  INDEX_BIT_LEN  chain head index.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_match  out  1  at least one entry matched.
- rsp_ruleID  out  INDEX_BIT_LEN  selected ruleID; 0 if no match.
- rsp_hops  out  HOP_W  entries visited.
- rsp_overflow  out  1  walk stopped at MAX_HOPS without reaching NULL_INDEX.
- upd_valid  in  1  table write request.
- upd_ready  out  1  write accepted.
- upd_index  in  INDEX_BIT_LEN  entry to write.
- upd_data  in  ENTRY_DATA_WIDTH  entry contents.
- tbl_search_index  out  INDEX_BIT_LEN  to table search_index.
- tbl_tupleData  out  PACKET_BIT_LEN  to table tupleData.
- tbl_we  out  1  to table we.
- tbl_din  out  ENTRY_DATA_WIDTH  to table din.
- tbl_match  in  1  from table, registered.
- tbl_ruleID  in  INDEX_BIT_LEN  from table, registered.
- tbl_next_index  in  INDEX_BIT_LEN  from table, registered.

Behaviour:
- Reset: state IDLE. rsp_valid, rsp_match, rsp_overflow, tbl_we = 0. rsp_ruleID, rsp_hops, tbl_search_index, tbl_tupleData, tbl_din = 0. Arbitration pointer = REQ last. Any in-flight search or write is discarded; no response is produced for it.
- All tbl_* outputs are registered. The table has 1-cycle read latency: an index driven in ISSUE yields tbl_* results sampled in WAIT. tbl_match is qualified only in WAIT; it is ignored in every other state.
- States: IDLE, ISSUE, WAIT, RESP, WRITE.
- IDLE grant rule: update wins if upd_valid && (!req_valid || last grant was REQ); otherwise a valid request wins, so the two alternate under contention.
- req_ready = IDLE && request granted. upd_ready = IDLE && update granted. Both are combinational from state and valids.
- IDLE, update granted: latch upd_index and upd_data; go to WRITE.
- IDLE, request granted: latch tuple and start index, clear accumulators. If start index == NULL_INDEX, go to RESP with match=0, hops=0, overflow=0. Otherwise go to ISSUE.
- WRITE: tbl_we=1 for exactly one cycle, with tbl_search_index=upd_index and tbl_din=upd_data; then IDLE. tbl_we is 0 in all other states.
- ISSUE: drive cur_idx on tbl_search_index and the tuple on tbl_tupleData; go to WAIT. Each hop therefore costs 2 cycles.
- WAIT: hops += 1. If tbl_match, update the accumulator per the feature below. Then:
  - tbl_next_index == NULL_INDEX: go to RESP.
  - else hops == MAX_HOPS: go to RESP with overflow=1.
  - else: cur_idx <= tbl_next_index; go to ISSUE.
- RESP: rsp_valid=1 with all rsp_* stable until rsp_ready is sampled high; then IDLE. While in RESP, a new request cannot be accepted.
- Latency for a chain of N entries, rsp_ready held high: response valid 2N+1 cycles after the accept edge.
- Table contents are never read during WRITE, and a write can never overlap a walk.

Optional Feature:
- Macro: G2_FIRST_MATCH_EN.
- Defined: the walk terminates in the WAIT cycle of the first match (go to RESP). rsp_ruleID is that entry's ruleID; rsp_overflow=0.
- Undefined: the full chain is walked. rsp_ruleID is the numerically smallest ruleID among all matching entries (highest priority); ties keep the first seen.

Test Plan:
- Write entry 5 (next=7FF, ruleID=12, fields match tuple T), then search T at start 5 → write pulse of 1 cycle; rsp match=1, ruleID=12, hops=1, overflow=0, rsp_valid 3 cycles after accept.
- Chain 2→9→4→7FF with matches at 9 (ruleID 30) and 4 (ruleID 8) → without macro: ruleID=8, hops=3. With G2_FIRST_MATCH_EN: ruleID=30, hops=2.
- Start index 7FF → rsp match=0, ruleID=0, hops=0, one cycle after accept.
- Self-loop entry 3 (next=3) → rsp hops=19, overflow=1, match per contents.
- upd_valid and req_valid both high in IDLE for 4 transactions each → grants alternate UPD, REQ, UPD, REQ…; no tbl_we asserted while in ISSUE or WAIT.
- rst_n low for 1 cycle during WAIT of a 3-hop walk, with rsp_ready held low → all outputs return to reset values immediately; no rsp_valid for the aborted search; next request completes normally.
